// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - bit-serial add/subtract controller around one shared full add/sub cell
// Operands are latched on start and consumed LSB first, one bit per clock.

module one_bit_adder_subtractor (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   input  logic op_i,
   output logic sum_o,
   output logic cout_o
);

   logic b_eff;

   // Subtraction inverts b here; the +1 comes from the carry seed in the controller.
   assign b_eff  = b_i ^ op_i;
   assign sum_o  = a_i ^ b_eff ^ cin_i;
   assign cout_o = (a_i & b_eff) | (a_i & cin_i) | (b_eff & cin_i);

endmodule

module serial_addsub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             opcode,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic             op_q, op_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             cmsb_q, cmsb_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             cell_sum;
   logic             cell_cout;

   one_bit_adder_subtractor u_cell (
      .a_i    (a_sr_q[0]),
      .b_i    (b_sr_q[0]),
      .cin_i  (carry_q),
      .op_i   (op_q),
      .sum_o  (cell_sum),
      .cout_o (cell_cout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         op_q     <= 1'b0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         cmsb_q   <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         op_q     <= op_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         cmsb_q   <= cmsb_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      op_d     = op_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      cmsb_d   = cmsb_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      busy     = 1'b0;
      done     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_sr_d  = a;
               b_sr_d  = b;
               op_d    = opcode;
               carry_d = opcode;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            busy     = 1'b1;
            result_d = {cell_sum, result_q[WIDTH-1:1]};
            carry_d  = cell_cout;
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            if (cnt_q == CNT_PRE) begin
               cmsb_d = cell_cout;
            end
            if (cnt_q == CNT_LAST) begin
               cout_d  = cell_cout;
               ovf_d   = cmsb_q ^ cell_cout;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign result   = result_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb/tb_serial_addsub_ctrl.sv - directed self-checking bench for serial_addsub_ctrl
// Inputs change on the negative edge; outputs are sampled on the negative edge.

module tb_serial_addsub_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         reset;
   logic         start;
   logic [W-1:0] a_s;
   logic [W-1:0] b_s;
   logic         op_s;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;

   int total;
   int bad;

   serial_addsub_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .a        (a_s),
      .b        (b_s),
      .opcode   (op_s),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Runs one operation and watches 12 cycles after acceptance. With inject set,
   // start is pulsed with junk operands in cycles T+3 and T+9 (the DONE cycle).
   task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic top, input bit inject, input logic [W-1:0] exp_res,
                         input logic exp_cout, input logic exp_ovf);
      int first_done;
      int n_done;
      int n_busy;
      bit busy_ok;
      first_done = -1;
      n_done     = 0;
      n_busy     = 0;
      busy_ok    = 1'b1;
      @(negedge clk);
      start = 1'b1;
      a_s   = ta;
      b_s   = tb;
      op_s  = top;
      @(posedge clk);
      #1;
      start = 1'b0;
      a_s   = ~ta;
      b_s   = ~tb;
      op_s  = ~top;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) n_busy++;
         if (busy != ((k >= 1) && (k <= W))) busy_ok = 1'b0;
         if (done) begin
            n_done++;
            if (first_done < 0) begin
               first_done = k;
               check({tag, " result"}, 32'(result), 32'(exp_res));
               check({tag, " cout"}, 32'(cout), 32'(exp_cout));
               check({tag, " ovf"}, 32'(overflow), 32'(exp_ovf));
            end
         end
         if (inject && (k == 3 || k == 9)) begin
            start = 1'b1;
            a_s   = 8'hA5;
            b_s   = 8'h3C;
            op_s  = 1'b1;
         end
      end
      check({tag, " done_cycle"}, 32'(first_done), 32'(W + 1));
      check({tag, " done_count"}, 32'(n_done), 32'd1);
      check({tag, " busy_count"}, 32'(n_busy), 32'(W));
      check({tag, " busy_window"}, 32'(busy_ok), 32'd1);
      check({tag, " result_held"}, 32'(result), 32'(exp_res));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      start = 1'b0;
      a_s   = '0;
      b_s   = '0;
      op_s  = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst result", 32'(result), 32'd0);
      check("rst cout", 32'(cout), 32'd0);
      check("rst ovf", 32'(overflow), 32'd0);

      // start held high while busy must not disturb the first operation
      run_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0);
      run_op("sub_50_20", 8'h50, 8'h20, 1'b1, 1'b0, 8'h30, 1'b1, 1'b0);
      run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
      run_op("sub_00_01", 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
      run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op("inject", 8'h35, 8'h4A, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0);

      // Abort: reset sampled at the end of cycle T+4.
      @(negedge clk);
      start = 1'b1;
      a_s   = 8'h12;
      b_s   = 8'h34;
      op_s  = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("abort busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort result", 32'(result), 32'd0);
      check("abort cout", 32'(cout), 32'd0);
      check("abort ovf", 32'(overflow), 32'd0);
      begin
         int n_done_abort;
         n_done_abort = 0;
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || busy) n_done_abort++;
         end
         check("abort quiet", 32'(n_done_abort), 32'd0);
      end

      run_op("after_abort", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
